// File: rtl/reg_pipe_set_pkg.sv
// reg_pipe_set_pkg: stage operation encoding shared by the pipeline and its stages.
package reg_pipe_set_pkg;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_SET} stage_op_e;
  function automatic stage_op_e stage_op(input logic set, input logic load);
    return set ? OP_SET : (load ? OP_LOAD : OP_HOLD);
  endfunction
endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one data+valid register with load/hold/set and async reset.
module reg_pipe_stage
  import reg_pipe_set_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  stage_op_e op;
  always_comb op = stage_op(set, load);
  // On a bubble only valid clears; data keeps its last value to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (op == OP_SET) begin
      valid <= 1'b0;
      data  <= SET_VALUE;
    end else if (op == OP_LOAD) begin
      valid <= prev_valid;
      if (prev_valid) data <= prev_data;
    end
  end
endmodule

// File: rtl/reg_pipe_set.sv
// reg_pipe_set: elastic DEPTH-stage valid/ready register pipeline with bubble collapsing and set flush.
module reg_pipe_set
  import reg_pipe_set_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] data [DEPTH];
  logic up, down;
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gen_stage
      // Stage g can load unless it and every stage after it is full and the output stalls.
      assign ready[g] = !(&valid[DEPTH-1:g]) | out_ready;
      if (g == 0) begin : gen_first
        reg_pipe_stage #(.WIDTH(WIDTH), .SET_VALUE(SET_VALUE), .RESET_VALUE(RESET_VALUE)) u_stage (
          .clk(clk), .rst_n(rst_n), .set(set), .load(ready[g]),
          .prev_valid(in_valid), .prev_data(in_data),
          .valid(valid[g]), .data(data[g])
        );
      end else begin : gen_next
        reg_pipe_stage #(.WIDTH(WIDTH), .SET_VALUE(SET_VALUE), .RESET_VALUE(RESET_VALUE)) u_stage (
          .clk(clk), .rst_n(rst_n), .set(set), .load(ready[g]),
          .prev_valid(valid[g-1]), .prev_data(data[g-1]),
          .valid(valid[g]), .data(data[g])
        );
      end
    end
  endgenerate
  assign in_ready  = ready[0] & !set;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign up   = in_valid & in_ready;
  assign down = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (set) count <= '0;
    else if (up & !down) count <= count + 1'b1;
    else if (!up & down) count <= count - 1'b1;
  end
endmodule

// File: tb/tb_reg_pipe_set.sv
// tb_reg_pipe_set: directed and randomised checks of reg_pipe_set at DEPTH 2 and DEPTH 4.
module tb_reg_pipe_set;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_set = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [31:0] a_in_data = '0;
  logic a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0] a_count;
  logic b_set = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_in_data = '0;
  logic b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [2:0] b_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_pipe_set #(.WIDTH(32), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .set(a_set), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .count(a_count)
  );
  reg_pipe_set #(.WIDTH(32), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .set(b_set), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    a_in_valid = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b0;
    tick(); tick();
    a_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", a_out_data); end
    checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", a_count); end
    repeat (3) tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL reset_b got valid %0b count %0d want 0 0", b_out_valid, b_count); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      a_in_valid = (i < 8); a_in_data = i + 1;
      #1;
      if (i < 8) begin
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, a_in_ready); end
      end
      tick();
      if (i == 0) begin
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got valid %0b want 0", a_out_valid); end
      end else begin
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== i) begin errors++; $display("FAIL stream_word[%0d] got %0b/%h want 1/%h", i, a_out_valid, a_out_data, i); end
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL stream_drain got valid %0b count %0d want 0 0", a_out_valid, a_count); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hA;
    tick();
    a_in_data = 32'hB;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b got %0b want 1", a_in_ready); end
    tick();
    a_in_data = 32'hC;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0b want 0", a_in_ready); end
    tick();
    checks++; if (a_count !== 2'd2 || a_out_data !== 32'hA) begin errors++; $display("FAIL bp_hold got count %0d data %h want 2 0000000a", a_count, a_out_data); end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_comb_ready got %0b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin errors++; $display("FAIL bp_out_b got %0b/%h want 1/0000000b", a_out_valid, a_out_data); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hC) begin errors++; $display("FAIL bp_out_c got %0b/%h want 1/0000000c", a_out_valid, a_out_data); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL bp_empty got valid %0b count %0d want 0 0", a_out_valid, a_count); end
  endtask

  task automatic test_bubble_collapse();
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = w[0];
    tick();
    b_in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL bubble_early[%0d] got %0b want 0", i, b_out_valid); end
      tick();
    end
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== w[0]) begin errors++; $display("FAIL bubble_arrive got %0b/%h want 1/%h", b_out_valid, b_out_data, w[0]); end
    for (int i = 1; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_data = w[i];
      #1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL bubble_accept[%0d] got %0b want 1", i, b_in_ready); end
      tick();
    end
    b_in_valid = 1'b0;
    #1;
    checks++; if (b_count !== 3'd4 || b_in_ready !== 1'b0) begin errors++; $display("FAIL bubble_full got count %0d ready %0b want 4 0", b_count, b_in_ready); end
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== w[i]) begin errors++; $display("FAIL bubble_drain[%0d] got %0b/%h want 1/%h", i, b_out_valid, b_out_data, w[i]); end
      tick();
    end
    checks++; if (b_out_valid !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL bubble_empty got valid %0b count %0d want 0 0", b_out_valid, b_count); end
  endtask

  task automatic test_set();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h1234;
    tick(); tick();
    checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL set_pre_count got %0d want 2", a_count); end
    a_set = 1'b1; a_in_data = 32'h55;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL set_in_ready got %0b want 0", a_in_ready); end
    tick();
    a_set = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'hFFFFFFFF || a_count !== 2'd0) begin errors++; $display("FAIL set_flush got %0b/%h/%0d want 0/ffffffff/0", a_out_valid, a_out_data, a_count); end
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin errors++; $display("FAIL set_no_accept got valid %0b count %0d want 0 0", a_out_valid, a_count); end
    rst_n = 1'b0;
    a_set = 1'b1;
    tick();
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL set_ignored_in_reset got %h want 00000000", a_out_data); end
    rst_n = 1'b1;
    tick();
    a_set = 1'b0;
    checks++; if (a_out_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL set_after_release got %h want ffffffff", a_out_data); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic iv, orr, ir, ov;
    logic [31:0] od, d;
    for (int c = 0; c < 2000; c++) begin
      iv = 1'($urandom_range(0, 1)); orr = 1'($urandom_range(0, 1)); d = $urandom;
      a_in_valid = iv; a_out_ready = orr; a_in_data = d;
      #1;
      ir = a_in_ready; ov = a_out_valid; od = a_out_data;
      checks++; if (ir !== !(q.size() == 2 && !orr)) begin errors++; $display("FAIL rand_in_ready[%0d] got %0b size %0d out_ready %0b", c, ir, q.size(), orr); end
      if (ov && orr) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_dup[%0d] got %h want no output", c, od);
        end else begin
          checks++; if (od !== q[0]) begin errors++; $display("FAIL rand_order[%0d] got %h want %h", c, od, q[0]); end
          void'(q.pop_front());
        end
      end
      if (iv && ir) q.push_back(d);
      tick();
      checks++; if (a_count !== 2'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", c, a_count, q.size()); end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (a_out_valid && q.size() > 0) begin
        checks++; if (a_out_data !== q[0]) begin errors++; $display("FAIL rand_tail got %h want %h", a_out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() != 0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rand_loss got %0d left valid %0b want 0 0", q.size(), a_out_valid); end
  endtask

  initial begin
    tick();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_set();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
